// File: rtl/spi_slave_rx_if.sv
// SPI pin and receive-handshake bundle for spi_slave_rx.
// The slave modport is the endpoint's view; master is the driving side.
interface spi_slave_rx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  SCLK;
   logic                  SS_N;
   logic                  MOSI;
   logic                  MISO;
   logic [DATA_WIDTH-1:0] tx_data;
   logic [DATA_WIDTH-1:0] rx_data;
   logic                  rx_valid;
   logic                  rx_ack;
   logic                  overrun;
   logic                  frame_err;

   modport slave (
      input  SCLK, SS_N, MOSI, tx_data, rx_ack,
      output MISO, rx_data, rx_valid, overrun, frame_err
   );

   modport master (
      output SCLK, SS_N, MOSI, tx_data, rx_ack,
      input  MISO, rx_data, rx_valid, overrun, frame_err
   );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled pins, MSB-first receive with valid/ack, response shift-out.
// Define SPI_SLAVE_ECHO_EN to answer with the last received word instead of tx_data.
module spi_slave_rx #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input logic            clk,
   input logic            reset,
   spi_slave_rx_if.slave  bus
);
   localparam int CNT_W = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

   state_t                state;
   state_t                state_next;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                  sclk_s;
   logic                  ss_s;
   logic                  mosi_s;
   logic                  sclk_d;
   logic                  ss_d;
   logic                  sclk_rise;
   logic                  sclk_fall;
   logic                  ss_rise;
   logic                  ss_fall;

   logic [DATA_WIDTH-2:0] rx_shift;
   logic [DATA_WIDTH-1:0] rx_word;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic [DATA_WIDTH-1:0] tx_src;
   logic [CNT_W-1:0]      bit_cnt;

   logic                  do_load;
   logic                  do_rise;
   logic                  do_fall;
   logic                  do_end;
   logic                  word_done;

   logic                  miso_q;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  rx_valid_q;
   logic                  overrun_q;
   logic                  frame_err_q;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Chains reset to 0 so SS_N must be seen high before the FSM can arm.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync <= '0;
         ss_sync   <= '0;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b0;
         sclk_rise <= 1'b0;
         sclk_fall <= 1'b0;
         ss_rise   <= 1'b0;
         ss_fall   <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.SS_N};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
         sclk_d    <= sclk_s;
         ss_d      <= ss_s;
         sclk_rise <= sclk_s & ~sclk_d;
         sclk_fall <= ~sclk_s & sclk_d;
         ss_rise   <= ss_s & ~ss_d;
         ss_fall   <= ~ss_s & ss_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      do_load    = 1'b0;
      do_rise    = 1'b0;
      do_fall    = 1'b0;
      do_end     = 1'b0;
      case (state)
         IDLE:    if (ss_s) state_next = ARMED;
         ARMED:   if (ss_fall) begin
                     state_next = SHIFT;
                     do_load    = 1'b1;
                  end
         SHIFT:   if (ss_rise) begin
                     state_next = ARMED;
                     do_end     = 1'b1;
                  end else begin
                     do_rise = sclk_rise;
                     do_fall = sclk_fall;
                  end
         default: state_next = IDLE;
      endcase
   end

   assign rx_word   = {rx_shift, mosi_s};
   assign word_done = do_rise && (bit_cnt == CNT_W'(DATA_WIDTH - 1));

`ifdef SPI_SLAVE_ECHO_EN
   logic [DATA_WIDTH-1:0] echo_word;
   logic                  unused_tx;

   always_ff @(posedge clk) begin
      if (reset)          echo_word <= '0;
      else if (word_done) echo_word <= rx_word;
   end

   assign tx_src    = echo_word;
   assign unused_tx = ^bus.tx_data;
`else
   assign tx_src = bus.tx_data;
`endif

   // A fall with bit_cnt==0 follows a completed word, so the next response is loaded.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
         tx_shift <= '0;
         miso_q   <= 1'b1;
      end else begin
         if (do_load) begin
            bit_cnt  <= '0;
            tx_shift <= tx_src;
            miso_q   <= tx_src[DATA_WIDTH-1];
         end else if (do_rise) begin
            rx_shift <= rx_word[DATA_WIDTH-2:0];
            bit_cnt  <= word_done ? '0 : bit_cnt + 1'b1;
         end else if (do_fall) begin
            if (bit_cnt == '0) begin
               tx_shift <= tx_src;
               miso_q   <= tx_src[DATA_WIDTH-1];
            end else begin
               tx_shift <= tx_shift << 1;
               miso_q   <= tx_shift[DATA_WIDTH-2];
            end
         end else if (state != SHIFT || do_end) begin
            miso_q <= 1'b1;
         end
      end
   end

   // An ack landing with a completion frees the slot, so the new word is taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (word_done) begin
            if (!rx_valid_q || bus.rx_ack) begin
               rx_data_q  <= rx_word;
               rx_valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (bus.rx_ack) begin
            rx_valid_q <= 1'b0;
         end
         if (do_end && bit_cnt != '0) frame_err_q <= 1'b1;
      end
   end

   assign bus.MISO      = miso_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.overrun   = overrun_q;
   assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives mode-0 frames and checks outputs against
// a word-level model of the receive, handshake and response rules.
`timescale 1ns/1ps
module tb_spi_slave_rx;
   localparam int DW     = 8;
   localparam int SYNC   = 2;
   localparam int HALF   = SYNC + 4;
   localparam int SETTLE = SYNC + 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   spi_slave_rx_if #(.DATA_WIDTH(DW)) bus ();

   spi_slave_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks     = 0;
   int passes     = 0;
   int cycle      = 0;
   int lastChange = 0;

   logic [DW-1:0] mData;
   logic [DW-1:0] mEcho;
   logic          mValid;
   logic          mOverrun;
   logic          mFrameErr;
   logic          mInFrame;
   logic          mArmed;
   int            mBits;

   logic [DW-1:0] txq[$];
   logic [DW-1:0] rxq[$];
   logic [DW-1:0] got;
   logic [DW-1:0] firstRead;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Word-level rule: a finished word is taken when the slot is free or acked, else overrun.
   task automatic modelWord(input logic [DW-1:0] word, input bit ack);
      mEcho = word;
      if (!mValid || ack) begin
         mData  = word;
         mValid = 1'b1;
      end else begin
         mOverrun = 1'b1;
      end
   endtask

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      if (!reset && (cycle - lastChange) >= SETTLE) begin
         checkOutput("rx_data", 32'(bus.rx_data), 32'(mData));
         checkOutput("rx_valid", 32'(bus.rx_valid), 32'(mValid));
         checkOutput("overrun", 32'(bus.overrun), 32'(mOverrun));
         checkOutput("frame_err", 32'(bus.frame_err), 32'(mFrameErr));
         if (!mInFrame) checkOutput("miso_idle", 32'(bus.MISO), 32'd1);
      end
   end

   task automatic applyReset();
      @(negedge clk);
      reset     = 1'b1;
      mData     = '0;
      mEcho     = '0;
      mValid    = 1'b0;
      mOverrun  = 1'b0;
      mFrameErr = 1'b0;
      mInFrame  = 1'b0;
      mBits     = 0;
      repeat (3) @(negedge clk);
      reset      = 1'b0;
      mArmed     = bus.SS_N;
      lastChange = cycle;
      repeat (2 * HALF) @(negedge clk);
   endtask

   // Shifts the top nbits of word; the master samples MISO right before each rise.
   task automatic applyStimulus(input logic [DW-1:0] word, input int nbits,
                                input bit ackOnLast, output logic [DW-1:0] readWord);
      readWord = '0;
      for (int b = 0; b < nbits; b++) begin
         bus.MOSI = word[DW-1-b];
         repeat (HALF) @(negedge clk);
         readWord   = {readWord[DW-2:0], bus.MISO};
         bus.SCLK   = 1'b1;
         lastChange = cycle;
         if (mInFrame) begin
            mBits++;
            if (mBits == DW) begin
               mBits = 0;
               modelWord(word, ackOnLast && (b == nbits - 1));
            end
         end
         for (int c = 1; c <= HALF; c++) begin
            @(negedge clk);
            bus.rx_ack = ackOnLast && (b == nbits - 1) && (c == SYNC + 1);
         end
         bus.SCLK   = 1'b0;
         lastChange = cycle;
      end
   endtask

   task automatic sendFrame(input int lastBits, input bit ackLast);
      logic [DW-1:0] readWord;
      logic [DW-1:0] expTx;
      int n;
      n = txq.size();
      rxq.delete();
      bus.SS_N   = 1'b0;
      lastChange = cycle;
      if (mArmed) begin
         mInFrame = 1'b1;
         mBits    = 0;
      end
      for (int i = 0; i < n; i++) begin
         int nb;
         nb = (i == n - 1) ? lastBits : DW;
`ifdef SPI_SLAVE_ECHO_EN
         expTx = mEcho;
`else
         expTx = bus.tx_data;
`endif
         applyStimulus(txq[i], nb, ackLast && (i == n - 1), readWord);
         rxq.push_back(readWord);
         if (mInFrame && nb == DW) checkOutput("miso_word", 32'(readWord), 32'(expTx));
      end
      repeat (HALF) @(negedge clk);
      bus.SS_N   = 1'b1;
      lastChange = cycle;
      if (mInFrame && mBits != 0) mFrameErr = 1'b1;
      mInFrame = 1'b0;
      mArmed   = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      txq.delete();
   endtask

   task automatic doAck();
      @(negedge clk);
      bus.rx_ack = 1'b1;
      lastChange = cycle;
      mValid     = 1'b0;
      @(negedge clk);
      bus.rx_ack = 1'b0;
      checkOutput("ack_clears_valid", 32'(bus.rx_valid), 32'd0);
      repeat (HALF) @(negedge clk);
   endtask

   initial begin
      bus.SCLK    = 1'b0;
      bus.SS_N    = 1'b1;
      bus.MOSI    = 1'b0;
      bus.rx_ack  = 1'b0;
      bus.tx_data = '0;
      mArmed      = 1'b0;

      applyReset();
      checkOutput("reset_rx_data", 32'(bus.rx_data), 32'h0);
      checkOutput("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
      checkOutput("reset_overrun", 32'(bus.overrun), 32'd0);
      checkOutput("reset_frame_err", 32'(bus.frame_err), 32'd0);
      checkOutput("reset_miso", 32'(bus.MISO), 32'd1);

      $display("[TB] single byte");
      bus.tx_data = 8'h3C;
      txq.push_back(8'hA5);
      sendFrame(DW, 1'b0);
`ifndef SPI_SLAVE_ECHO_EN
      checkOutput("single_miso_read", 32'(rxq[0]), 32'h3C);
`endif
      checkOutput("single_rx_data", 32'(bus.rx_data), 32'hA5);
      checkOutput("single_rx_valid", 32'(bus.rx_valid), 32'd1);
      doAck();

      $display("[TB] overrun");
      bus.tx_data = 8'h5A;
      txq.push_back(8'h01);
      txq.push_back(8'h02);
      txq.push_back(8'h03);
      sendFrame(DW, 1'b0);
      checkOutput("overrun_rx_data", 32'(bus.rx_data), 32'h01);
      checkOutput("overrun_flag", 32'(bus.overrun), 32'd1);
      checkOutput("overrun_frame_err", 32'(bus.frame_err), 32'd0);
      applyReset();

      $display("[TB] ack/completion collision");
      txq.push_back(8'hFF);
      txq.push_back(8'hFE);
      sendFrame(DW, 1'b1);
      checkOutput("collide_rx_data", 32'(bus.rx_data), 32'hFE);
      checkOutput("collide_rx_valid", 32'(bus.rx_valid), 32'd1);
      checkOutput("collide_overrun", 32'(bus.overrun), 32'd0);
      doAck();

      $display("[TB] abort");
      txq.push_back(8'hC3);
      sendFrame(5, 1'b0);
      checkOutput("abort_frame_err", 32'(bus.frame_err), 32'd1);
      checkOutput("abort_no_partial", 32'(bus.rx_valid), 32'd0);
      txq.push_back(8'h55);
      sendFrame(DW, 1'b0);
      checkOutput("abort_next_data", 32'(bus.rx_data), 32'h55);
      checkOutput("abort_sticky", 32'(bus.frame_err), 32'd1);
      doAck();

      $display("[TB] reset mid-frame");
      bus.SS_N   = 1'b0;
      lastChange = cycle;
      mInFrame   = 1'b1;
      mBits      = 0;
      applyStimulus(8'hE0, 3, 1'b0, got);
      applyReset();
      applyStimulus(8'hFF, 5, 1'b0, got);
      checkOutput("midreset_rx_data", 32'(bus.rx_data), 32'h0);
      checkOutput("midreset_frame_err", 32'(bus.frame_err), 32'd0);
      checkOutput("midreset_miso", 32'(bus.MISO), 32'd1);
      bus.SS_N   = 1'b1;
      lastChange = cycle;
      mArmed     = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      txq.push_back(8'h81);
      sendFrame(DW, 1'b0);
      checkOutput("midreset_new_data", 32'(bus.rx_data), 32'h81);
      checkOutput("midreset_new_valid", 32'(bus.rx_valid), 32'd1);

`ifdef SPI_SLAVE_ECHO_EN
      $display("[TB] echo");
      applyReset();
      txq.push_back(8'h12);
      sendFrame(DW, 1'b0);
      firstRead = rxq[0];
      txq.push_back(8'h34);
      sendFrame(DW, 1'b0);
      checkOutput("echo_first_read", 32'(firstRead), 32'h00);
      checkOutput("echo_second_read", 32'(rxq[0]), 32'h12);
`else
      firstRead = '0;
`endif

      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
